// File: rtl/delay_pipe.sv
// Stallable, run-time tapped delay line for WIDTH-bit data plus valid sideband; delay = d_eff+1 enabled edges.
// en=0 freezes every register (stall); rst/flush clear contents to RESET_VAL with valid low.
module delay_pipe #(
  parameter int               WIDTH     = 16,
  parameter int               MAX_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           flush,
  input  logic [$clog2(MAX_DEPTH)-1:0]   depth_sel,
  input  logic [WIDTH-1:0]               din,
  input  logic                           din_valid,
  output logic [WIDTH-1:0]               dout,
  output logic                           dout_valid,
  output logic                           primed,
  output logic [$clog2(MAX_DEPTH+1)-1:0] fill
);

  localparam int SW = $clog2(MAX_DEPTH);
  localparam int FW = $clog2(MAX_DEPTH + 1);
  localparam logic [SW-1:0] DEEPEST  = SW'(MAX_DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(MAX_DEPTH);

  logic [WIDTH-1:0]     stage [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld;
  logic [SW-1:0]        d_eff;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
      vld  <= '0;
      fill <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
      vld <= {vld[MAX_DEPTH-2:0], din_valid};
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Selects beyond the last stage only exist when MAX_DEPTH is not a power of two.
  generate
    if ((1 << SW) > MAX_DEPTH) begin : g_clamp
      assign d_eff = (depth_sel > DEEPEST) ? DEEPEST : depth_sel;
    end else begin : g_noclamp
      assign d_eff = depth_sel;
    end
  endgenerate

  assign dout       = stage[d_eff];
  assign dout_valid = vld[d_eff];
  assign primed     = (fill > FW'(d_eff));

endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe: an 8-deep default instance and a 6-deep instance with nonzero reset value.
module tb_delay_pipe;

  logic        clk = 1'b0;
  logic        rst, en, flush, din_valid;
  logic [15:0] din;
  logic [2:0]  depth_sel0, depth_sel1;
  logic [15:0] dout0, dout1;
  logic        dout_valid0, dout_valid1, primed0, primed1;
  logic [3:0]  fill0;
  logic [2:0]  fill1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  delay_pipe #(.WIDTH(16), .MAX_DEPTH(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .depth_sel(depth_sel0),
    .din(din), .din_valid(din_valid), .dout(dout0), .dout_valid(dout_valid0),
    .primed(primed0), .fill(fill0)
  );

  delay_pipe #(.WIDTH(16), .MAX_DEPTH(6), .RESET_VAL(16'h00C3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .depth_sel(depth_sel1),
    .din(din), .din_valid(din_valid), .dout(dout1), .dout_valid(dout_valid1),
    .primed(primed1), .fill(fill1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b0; din = 16'h0; din_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] vpat;

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; din = 16'h0; din_valid = 1'b0;
    depth_sel0 = 3'd1; depth_sel1 = 3'd1;

    // Reset / basic at d=1
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_dout", dout0, 32'h0);
      check("rst_vld", dout_valid0, 32'h0);
      check("rst_primed", primed0, 32'h0);
      check("rst_fill", fill0, 32'h0);
      check("rst_dout_rv", dout1, 32'h00C3);
    end
    rst = 1'b0;
    din = 16'h0001; din_valid = 1'b1;
    tick();
    check("b1_dout", dout0, 32'h0);
    check("b1_vld", dout_valid0, 32'h0);
    check("b1_primed", primed0, 32'h0);
    din = 16'h0002;
    tick();
    check("b2_dout", dout0, 32'h0001);
    check("b2_vld", dout_valid0, 32'h1);
    check("b2_primed", primed0, 32'h1);
    din = 16'h0003;
    tick();
    check("b3_dout", dout0, 32'h0002);

    // Full depth d=7, ramp 0x10..0x1F
    do_reset();
    depth_sel0 = 3'd7;
    for (int k = 1; k <= 16; k++) begin
      din = 16'h0010 + 16'(k - 1); din_valid = 1'b1;
      tick();
      check("full_dout", dout0, (k >= 8) ? 32'h10 + 32'(k - 8) : 32'h0);
      check("full_vld", dout_valid0, (k >= 8) ? 32'h1 : 32'h0);
      check("full_fill", fill0, (k >= 8) ? 32'd8 : 32'(k));
      check("full_primed", primed0, (k >= 8) ? 32'h1 : 32'h0);
    end

    // Stall at d=2: en low 3 cycles after 0xA2
    do_reset();
    depth_sel0 = 3'd2;
    din = 16'h00A1; din_valid = 1'b1; tick(); check("st1", dout0, 32'h0);
    din = 16'h00A2;                   tick(); check("st2", dout0, 32'h0);
    en = 1'b0; din = 16'h00EE;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("st_hold_dout", dout0, 32'h0);
      check("st_hold_fill", fill0, 32'd2);
    end
    en = 1'b1; din = 16'h00A3; tick(); check("st6", dout0, 32'h00A1);
    din = 16'h0000; din_valid = 1'b0;
    tick(); check("st7", dout0, 32'h00A2);
    tick(); check("st8", dout0, 32'h00A3);
    check("st8_vld", dout_valid0, 32'h1);
    tick(); check("st9_vld", dout_valid0, 32'h0);

    // Flush collision
    do_reset();
    depth_sel0 = 3'd7;
    din = 16'h0055; din_valid = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("fl_pre_dout", dout0, 32'h0055);
    check("fl_pre_fill", fill0, 32'd8);
    flush = 1'b1; din = 16'h00FF;
    tick();
    check("fl_dout", dout0, 32'h0);
    check("fl_vld", dout_valid0, 32'h0);
    check("fl_fill", fill0, 32'h0);
    check("fl_primed", primed0, 32'h0);
    check("fl_dout_rv", dout1, 32'h00C3);
    flush = 1'b0; din = 16'h0000; din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fl_no_ff", dout0, 32'h0);
    end

    // Retap and clamp on the 6-deep instance
    do_reset();
    depth_sel1 = 3'd3;
    for (int k = 1; k <= 16; k++) begin
      if (k == 7) depth_sel1 = 3'd2;
      if (k == 9) depth_sel1 = 3'd7;
      din = 16'(k - 1); din_valid = 1'b1;
      tick();
      if (k == 6) begin
        check("rt_d3", dout1, 32'd2);
        depth_sel1 = 3'd2;
        #1;
        check("rt_immediate", dout1, 32'd3);
      end else if (k == 7 || k == 8) begin
        check("rt_d2", dout1, 32'(k - 3));
      end else if (k >= 9) begin
        check("rt_clamp", dout1, 32'(k - 6));
      end
    end
    check("rt_fill_sat", fill1, 32'd6);
    check("rt_primed", primed1, 32'h1);

    // Valid sideband pattern 1,0,1,1 at d=4
    do_reset();
    depth_sel0 = 3'd4;
    vpat = 4'b1101;
    for (int k = 1; k <= 10; k++) begin
      din = 16'h0030 + 16'(k - 1);
      din_valid = (k <= 4) ? vpat[k-1] : 1'b0;
      tick();
      if (k >= 5) begin
        check("vs_dout", dout0, 32'h30 + 32'(k - 5));
        check("vs_vld", dout_valid0, (k - 5 < 4) ? 32'(vpat[k-5]) : 32'h0);
      end else begin
        check("vs_pre_vld", dout_valid0, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
